stable_delta_tracker: RTL and testbench



---
 rtl/vital_pkg.sv | 18 +
 rtl/run_length_detector.sv | 53 +++++
 rtl/stable_delta_tracker.sv | 112 +++++++++++
 tb/tb_stable_delta_tracker.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/vital_pkg.sv
// ---- vital_pkg: shared types and helpers for vital-sign trackers (rev 1.0) ----
`default_nettype none

package vital_pkg;

  typedef enum logic [0:0] {
    EMPTY    = 1'b0,
    TRACKING = 1'b1
  } ref_state_t;

  // Bits needed to hold values 0..max_val inclusive.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/run_length_detector.sv
// ---- run_length_detector: counts consecutive equal valid samples (rev 1.0) ----
`default_nettype none

module run_length_detector
  import vital_pkg::*;
#(
  parameter int WIDTH = 6,
  parameter int DEPTH = 4
) (
  input  logic             slow,
  input  logic             reset,
  input  logic             sample_valid,
  input  logic [WIDTH-1:0] sample,
  output logic             stable_hit
);

  localparam int            CW      = cnt_width(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] ONE_C   = CW'(1);

  logic [WIDTH-1:0] last;
  logic             have_last;
  logic [CW-1:0]    run_cnt;
  logic [CW-1:0]    run_cnt_next;

  always_comb begin
    run_cnt_next = run_cnt;
    if (sample_valid) begin
      if (have_last && (sample == last)) begin
        run_cnt_next = (run_cnt == DEPTH_C) ? DEPTH_C : run_cnt + ONE_C;
      end else begin
        run_cnt_next = ONE_C;
      end
    end
    // Fires only on the DEPTH-1 -> DEPTH step, so a saturated run stays quiet.
    stable_hit = sample_valid && (run_cnt != DEPTH_C) && (run_cnt_next == DEPTH_C);
  end

  always_ff @(posedge slow) begin
    if (reset) begin
      last      <= '0;
      have_last <= 1'b0;
      run_cnt   <= '0;
    end else if (sample_valid) begin
      last      <= sample;
      have_last <= 1'b1;
      run_cnt   <= run_cnt_next;
    end
  end

endmodule

`default_nettype wire

// File: rtl/stable_delta_tracker.sv
// ---- stable_delta_tracker: stable-value events with rise/fall/delta and timeout (rev 1.0) ----
`default_nettype none

module stable_delta_tracker
  import vital_pkg::*;
#(
  parameter int WIDTH   = 6,
  parameter int DEPTH   = 4,
  parameter int HYST    = 0,
  parameter int TIMEOUT = 15
) (
  input  logic             slow,
  input  logic             reset,
  input  logic             sample_valid,
  input  logic [WIDTH-1:0] sample,
  output logic             stable_pulse,
  output logic [WIDTH-1:0] stable_value,
  output logic             rose,
  output logic             fell,
  output logic [WIDTH-1:0] delta,
  output logic             unstable
);

  localparam int             TW        = cnt_width(TIMEOUT);
  localparam logic [TW-1:0]  TIMEOUT_C = TW'(TIMEOUT);
  localparam logic [TW-1:0]  TONE_C    = TW'(1);
  localparam logic [WIDTH:0] HYST_C    = (WIDTH + 1)'(HYST);

  logic             stable_hit;
  ref_state_t       state, state_next;
  logic [WIDTH-1:0] value_next, delta_next, diff;
  logic             rose_next, fell_next, unstable_next;
  logic [TW-1:0]    to_cnt, to_next;

  run_length_detector #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_run (
    .slow        (slow),
    .reset       (reset),
    .sample_valid(sample_valid),
    .sample      (sample),
    .stable_hit  (stable_hit)
  );

  // Larger minus smaller keeps the magnitude within WIDTH bits.
  assign diff = (sample >= stable_value) ? (sample - stable_value) : (stable_value - sample);

  always_comb begin
    state_next    = state;
    value_next    = stable_value;
    rose_next     = rose;
    fell_next     = fell;
    delta_next    = delta;
    to_next       = to_cnt;
    unstable_next = unstable;

    if (stable_hit) begin
      unique case (state)
        EMPTY: begin
          value_next = sample;
          state_next = TRACKING;
        end
        TRACKING: begin
          delta_next = diff;
          rose_next  = (sample > stable_value) && ({1'b0, diff} > HYST_C);
          fell_next  = (sample < stable_value) && ({1'b0, diff} > HYST_C);
          value_next = sample;
        end
        default: state_next = EMPTY;
      endcase
    end

    // A stable event on the would-be timeout sample takes precedence.
    if (sample_valid) begin
      if (stable_hit) begin
        to_next       = '0;
        unstable_next = 1'b0;
      end else begin
        to_next = (to_cnt == TIMEOUT_C) ? to_cnt : to_cnt + TONE_C;
        if (to_next == TIMEOUT_C) begin
          unstable_next = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge slow) begin
    if (reset) begin
      state        <= EMPTY;
      stable_pulse <= 1'b0;
      stable_value <= '0;
      rose         <= 1'b0;
      fell         <= 1'b0;
      delta        <= '0;
      unstable     <= 1'b0;
      to_cnt       <= '0;
    end else begin
      state        <= state_next;
      stable_pulse <= stable_hit;
      stable_value <= value_next;
      rose         <= rose_next;
      fell         <= fell_next;
      delta        <= delta_next;
      unstable     <= unstable_next;
      to_cnt       <= to_next;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_stable_delta_tracker.sv
// ---- tb_stable_delta_tracker: directed self-checking bench (rev 1.0) ----
`default_nettype none

module tb_stable_delta_tracker;

  logic       slow = 1'b0;
  logic       reset = 1'b1;
  logic       sample_valid = 1'b0;
  logic [5:0] sample = '0;
  logic       stable_pulse;
  logic [5:0] stable_value;
  logic       rose;
  logic       fell;
  logic [5:0] delta;
  logic       unstable;

  int checks = 0;
  int failures = 0;

  stable_delta_tracker #(
    .WIDTH  (6),
    .DEPTH  (4),
    .HYST   (2),
    .TIMEOUT(15)
  ) dut (
    .slow        (slow),
    .reset       (reset),
    .sample_valid(sample_valid),
    .sample      (sample),
    .stable_pulse(stable_pulse),
    .stable_value(stable_value),
    .rose        (rose),
    .fell        (fell),
    .delta       (delta),
    .unstable    (unstable)
  );

  always #5 slow = ~slow;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  task automatic step(input logic v, input logic [5:0] val);
    @(negedge slow);
    sample_valid = v;
    sample       = val;
    @(posedge slow);
    #1;
  endtask

  task automatic feed(input logic [5:0] val, input int n);
    repeat (n) step(1'b1, val);
  endtask

  task automatic do_reset();
    @(negedge slow);
    reset        = 1'b1;
    sample_valid = 1'b0;
    @(posedge slow);
    @(posedge slow);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({stable_pulse, stable_value, rose, fell, delta, unstable} !== 16'h0) begin
      failures++;
      $display("FAIL reset_outputs: got %h want 0", {stable_pulse, stable_value, rose, fell, delta, unstable});
    end
  endtask

  task automatic test_first_event();
    feed(6'd20, 3);
    checks++;
    if (stable_pulse !== 1'b0) begin failures++; $display("FAIL first_early: got %0d want 0", stable_pulse); end
    step(1'b1, 6'd20);
    checks++;
    if (stable_pulse !== 1'b1) begin failures++; $display("FAIL first_pulse: got %0d want 1", stable_pulse); end
    checks++;
    if (stable_value !== 6'd20) begin failures++; $display("FAIL first_value: got %0d want 20", stable_value); end
    checks++;
    if ({rose, fell, delta} !== 8'h0) begin failures++; $display("FAIL first_flags: got %h want 0", {rose, fell, delta}); end
    step(1'b1, 6'd20);
    checks++;
    if (stable_pulse !== 1'b0) begin failures++; $display("FAIL first_refire: got %0d want 0", stable_pulse); end
  endtask

  task automatic test_rise_fall();
    feed(6'd25, 4);
    checks++;
    if ({stable_pulse, rose, fell} !== 3'b110) begin failures++; $display("FAIL rise_flags: got %b want 110", {stable_pulse, rose, fell}); end
    checks++;
    if (delta !== 6'd5 || stable_value !== 6'd25) begin failures++; $display("FAIL rise_delta: got %0d/%0d want 5/25", delta, stable_value); end
    feed(6'd22, 4);
    checks++;
    if ({stable_pulse, rose, fell} !== 3'b101) begin failures++; $display("FAIL fall_flags: got %b want 101", {stable_pulse, rose, fell}); end
    checks++;
    if (delta !== 6'd3 || stable_value !== 6'd22) begin failures++; $display("FAIL fall_delta: got %0d/%0d want 3/22", delta, stable_value); end
  endtask

  task automatic test_hysteresis();
    do_reset();
    feed(6'd30, 4);
    feed(6'd32, 4);
    checks++;
    if ({stable_pulse, rose, fell} !== 3'b100) begin failures++; $display("FAIL hyst_edge_flags: got %b want 100", {stable_pulse, rose, fell}); end
    checks++;
    if (delta !== 6'd2 || stable_value !== 6'd32) begin failures++; $display("FAIL hyst_edge_delta: got %0d/%0d want 2/32", delta, stable_value); end
    feed(6'd35, 4);
    checks++;
    if ({stable_pulse, rose, fell} !== 3'b110 || delta !== 6'd3) begin
      failures++;
      $display("FAIL hyst_over: got %b/%0d want 110/3", {stable_pulse, rose, fell}, delta);
    end
  endtask

  task automatic test_gaps();
    feed(6'd10, 2);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 6'd10);
      checks++;
      if (stable_pulse !== 1'b0) begin failures++; $display("FAIL gap_idle%0d: got %0d want 0", i, stable_pulse); end
    end
    step(1'b1, 6'd10);
    checks++;
    if (stable_pulse !== 1'b0) begin failures++; $display("FAIL gap_third: got %0d want 0", stable_pulse); end
    step(1'b1, 6'd10);
    checks++;
    if ({stable_pulse, fell, delta, stable_value} !== {2'b11, 6'd25, 6'd10}) begin
      failures++;
      $display("FAIL gap_pulse: got p%0d f%0d d%0d v%0d want p1 f1 d25 v10", stable_pulse, fell, delta, stable_value);
    end
    step(1'b1, 6'd10);
    feed(6'd11, 3);
    checks++;
    if (stable_pulse !== 1'b0) begin failures++; $display("FAIL broken_early: got %0d want 0", stable_pulse); end
    step(1'b1, 6'd11);
    checks++;
    if ({stable_pulse, rose, fell, delta, stable_value} !== {3'b100, 6'd1, 6'd11}) begin
      failures++;
      $display("FAIL broken_pulse: got p%0d r%0d f%0d d%0d v%0d want p1 r0 f0 d1 v11", stable_pulse, rose, fell, delta, stable_value);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    for (int i = 0; i < 14; i++) step(1'b1, (i % 2 == 0) ? 6'd1 : 6'd2);
    checks++;
    if (unstable !== 1'b0) begin failures++; $display("FAIL timeout_early: got %0d want 0", unstable); end
    step(1'b1, 6'd1);
    checks++;
    if (unstable !== 1'b1) begin failures++; $display("FAIL timeout_set: got %0d want 1", unstable); end
    feed(6'd7, 3);
    checks++;
    if ({stable_pulse, unstable} !== 2'b01) begin failures++; $display("FAIL timeout_hold: got %b want 01", {stable_pulse, unstable}); end
    step(1'b1, 6'd7);
    checks++;
    if ({stable_pulse, unstable, stable_value} !== {2'b10, 6'd7}) begin
      failures++;
      $display("FAIL timeout_clear: got p%0d u%0d v%0d want p1 u0 v7", stable_pulse, unstable, stable_value);
    end
  endtask

  task automatic test_timeout_boundary();
    do_reset();
    for (int i = 0; i < 11; i++) step(1'b1, (i % 2 == 0) ? 6'd1 : 6'd2);
    feed(6'd5, 3);
    checks++;
    if (unstable !== 1'b0) begin failures++; $display("FAIL tb_edge_pre: got %0d want 0", unstable); end
    step(1'b1, 6'd5);
    checks++;
    if ({stable_pulse, unstable} !== 2'b10) begin failures++; $display("FAIL tb_edge_win: got %b want 10", {stable_pulse, unstable}); end
  endtask

  task automatic test_reset_mid_run();
    feed(6'd40, 3);
    @(negedge slow);
    reset        = 1'b1;
    sample_valid = 1'b1;
    sample       = 6'd40;
    @(posedge slow);
    #1;
    reset = 1'b0;
    checks++;
    if ({stable_pulse, stable_value} !== 7'h0) begin
      failures++;
      $display("FAIL midrst_clear: got p%0d v%0d want p0 v0", stable_pulse, stable_value);
    end
    feed(6'd40, 3);
    checks++;
    if (stable_pulse !== 1'b0) begin failures++; $display("FAIL midrst_early: got %0d want 0", stable_pulse); end
    step(1'b1, 6'd40);
    checks++;
    if ({stable_pulse, rose, fell, delta, stable_value} !== {3'b100, 6'd0, 6'd40}) begin
      failures++;
      $display("FAIL midrst_pulse: got p%0d r%0d f%0d d%0d v%0d want p1 r0 f0 d0 v40", stable_pulse, rose, fell, delta, stable_value);
    end
    step(1'b0, 6'd0);
    checks++;
    if (stable_pulse !== 1'b0) begin failures++; $display("FAIL midrst_strobe: got %0d want 0", stable_pulse); end
  endtask

  initial begin
    test_reset();
    test_first_event();
    test_rise_fall();
    test_hysteresis();
    test_gaps();
    test_timeout();
    test_timeout_boundary();
    test_reset_mid_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
